// File: rtl/otter_iobus_uart_tx.sv
// otter_iobus_uart_tx
// Memory-mapped 8N1 UART transmitter on the OTTER IOBUS. Stores to TXDATA
// queue a byte in a small FIFO; a transmit FSM drains the FIFO onto TX with
// no idle gap between queued frames. STATUS reports FIFO and line state.
//
// Ports:
//   CLK           clock, rising edge
//   RESET_N       asynchronous active-low reset
//   IOBUS_ADDR    byte address from the CPU
//   IOBUS_OUT     write data from the CPU
//   IOBUS_WR      one-cycle write strobe
//   IOBUS_RD_DATA combinational read data (ORed into IOBUS_IN at top level)
//   TX            registered serial line, idles high
//   TX_BUSY       registered, high while a frame is on the line
//
// Registers:
//   BASE_ADDR     TXDATA  write: push IOBUS_OUT[7:0]; read: 0
//   BASE_ADDR+4   STATUS  read: {24'b0, count[3:0], ovf, busy, empty, full}
//                         write: IOBUS_OUT[3]=1 clears ovf
module otter_iobus_uart_tx #(
    parameter logic [31:0] BASE_ADDR  = 32'h1100_0100,
    parameter int unsigned CLK_RATE   = 50,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [31:0] IOBUS_ADDR,
    input  logic [31:0] IOBUS_OUT,
    input  logic        IOBUS_WR,
    output logic [31:0] IOBUS_RD_DATA,
    output logic        TX,
    output logic        TX_BUSY
);

    // Bit period in clocks, rounded to nearest
    localparam longint unsigned DIV_L =
        (64'(CLK_RATE) * 64'd1000000 + 64'(BAUD / 2)) / 64'(BAUD);
    localparam int unsigned DIV = 32'(DIV_L);
    localparam int unsigned BCW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW  = $clog2(FIFO_DEPTH + 1);

    localparam logic [BCW-1:0] BAUD_LAST   = BCW'(DIV - 1);
    localparam logic [31:0]    STATUS_ADDR = BASE_ADDR + 32'd4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_t;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic wr_data_c;
    logic wr_status_c;
    logic push_c;
    logic pop_c;

    assign wr_data_c   = IOBUS_WR && (IOBUS_ADDR == BASE_ADDR);
    assign wr_status_c = IOBUS_WR && (IOBUS_ADDR == STATUS_ADDR);

    // Only the low byte and the ovf-clear bit carry meaning
    logic unused_wdata;
    assign unused_wdata = ^IOBUS_OUT[31:8];

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          full_c;
    logic          empty_c;
    logic [7:0]    head_c;

    assign full_c  = (count_q == CW'(FIFO_DEPTH));
    assign empty_c = (count_q == '0);
    assign head_c  = mem[rd_ptr_q];

    // Full is sampled before the edge, so a write that coincides with a
    // pop from a full FIFO is still dropped.
    assign push_c = wr_data_c && !full_c;

    // Storage array has no reset; only pointers and count define contents
    always_ff @(posedge CLK) begin
        if (push_c) begin
            mem[wr_ptr_q] <= IOBUS_OUT[7:0];
        end
    end

    // Pointers and occupancy
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_c) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({push_c, pop_c})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Sticky overflow flag
    logic ovf_q;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ovf_q <= 1'b0;
        end else if (wr_status_c && IOBUS_OUT[3]) begin
            ovf_q <= 1'b0;
        end else if (wr_data_c && full_c) begin
            ovf_q <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Transmit FSM
    // ------------------------------------------------------------------
    state_t         state_q;
    state_t         state_d;
    logic [BCW-1:0] baud_q;
    logic [BCW-1:0] baud_d;
    logic [2:0]     bit_q;
    logic [2:0]     bit_d;
    logic [7:0]     shift_q;
    logic [7:0]     shift_d;
    logic           tx_q;
    logic           tx_d;
    logic           busy_q;
    logic           busy_d;
    logic           baud_end_c;

    assign baud_end_c = (baud_q == BAUD_LAST);

    // State and datapath registers; TX idles high through reset
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state, pop request and next line value
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop_c   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!empty_c) begin
                    pop_c   = 1'b1;
                    shift_d = head_c;
                    baud_d  = '0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (baud_end_c) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = ST_DATA;
                end else begin
                    baud_d = baud_q + BCW'(1);
                end
            end
            ST_DATA: begin
                if (baud_end_c) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP;
                    end
                end else begin
                    baud_d = baud_q + BCW'(1);
                end
            end
            ST_STOP: begin
                if (baud_end_c) begin
                    baud_d = '0;
                    // Chain straight into the next frame when data is waiting
                    if (!empty_c) begin
                        pop_c   = 1'b1;
                        shift_d = head_c;
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    baud_d = baud_q + BCW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Line level follows the state being entered so TX stays registered
        case (state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shift_d[0];
            default:  tx_d = 1'b1;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign TX      = tx_q;
    assign TX_BUSY = busy_q;

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    logic [3:0] count_sat_c;

    assign count_sat_c = (32'(count_q) > 32'd15) ? 4'hF : 4'(count_q);

    always_comb begin
        IOBUS_RD_DATA = '0;
        if (IOBUS_ADDR == STATUS_ADDR) begin
            IOBUS_RD_DATA = {24'b0, count_sat_c, ovf_q, busy_q, empty_c, full_c};
        end
    end

endmodule

// File: tb/tb_otter_iobus_uart_tx.sv
// Directed bench for otter_iobus_uart_tx at DIV=4, FIFO_DEPTH=4.
module tb_otter_iobus_uart_tx;

    localparam logic [31:0] BASE = 32'h1100_0100;
    localparam logic [31:0] STAT = BASE + 32'd4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        wr = 1'b0;
    logic [31:0] rd_data;
    logic        tx;
    logic        tx_busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    otter_iobus_uart_tx #(
        .BASE_ADDR  (BASE),
        .CLK_RATE   (1),
        .BAUD       (250000),
        .FIFO_DEPTH (4)
    ) dut (
        .CLK           (clk),
        .RESET_N       (rst_n),
        .IOBUS_ADDR    (addr),
        .IOBUS_OUT     (wdata),
        .IOBUS_WR      (wr),
        .IOBUS_RD_DATA (rd_data),
        .TX            (tx),
        .TX_BUSY       (tx_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        wr    = 1'b1;
        tick();
        wr    = 1'b0;
        wdata = '0;
        addr  = STAT;
    endtask

    task automatic read_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        check(tag, rd_data, exp);
    endtask

    // Checks one 40-cycle frame starting at the current cycle (start bit on the line)
    task automatic check_frame(input string tag, input logic [7:0] b);
        logic [9:0] bits;
        bits = {1'b1, b, 1'b0};
        for (int k = 0; k < 40; k++) begin
            check($sformatf("%s_tx_b%0d_c%0d", tag, k / 4, k % 4), 32'(tx), 32'(bits[k / 4]));
            check($sformatf("%s_busy_c%0d", tag, k), 32'(tx_busy), 32'd1);
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        int lows;

        // Reset state
        #1 rst_n = 1'b0;
        #1;
        check("rst_tx_during", 32'(tx), 32'd1);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(tx_busy), 32'd0);
        read_check("rst_status", STAT, 32'h2);

        // Single byte, upper data bits ignored
        bus_write(BASE, 32'hDEAD_BEA5);
        check("single_tx_pre", 32'(tx), 32'd1);
        check("single_busy_pre", 32'(tx_busy), 32'd0);
        read_check("single_status_pre", STAT, 32'h10);
        tick();
        check_frame("single", 8'hA5);
        check("single_busy_end", 32'(tx_busy), 32'd0);
        check("single_tx_end", 32'(tx), 32'd1);
        read_check("single_status_end", STAT, 32'h2);

        // Back-to-back frames with no idle gap
        bus_write(BASE, 32'h00);
        bus_write(BASE, 32'hFF);
        check_frame("b2b0", 8'h00);
        check_frame("b2b1", 8'hFF);
        check("b2b_busy_end", 32'(tx_busy), 32'd0);
        read_check("b2b_status_end", STAT, 32'h2);

        // Overflow
        for (int i = 1; i <= 6; i++) begin
            bus_write(BASE, 32'(i));
        end
        read_check("ovf_status_full", STAT, 32'h4D);
        bus_write(STAT, 32'h8);
        read_check("ovf_status_clr", STAT, 32'h45);
        repeat (34) tick();
        // This write lands on the edge that pops from a full FIFO: dropped
        bus_write(BASE, 32'h77);
        read_check("ovf_status_popedge", STAT, 32'h3C);
        n = 0;
        while (tx_busy && n < 1000) begin
            tick();
            n++;
        end
        check("ovf_busy_cycles", 32'(n), 32'd160);
        read_check("ovf_status_done", STAT, 32'h0A);
        bus_write(STAT, 32'h8);
        read_check("ovf_status_final", STAT, 32'h2);

        // Reset mid-frame during data bit 3
        bus_write(BASE, 32'h00);
        bus_write(BASE, 32'h00);
        bus_write(BASE, 32'h00);
        repeat (16) tick();
        check("midrst_tx_pre", 32'(tx), 32'd0);
        check("midrst_busy_pre", 32'(tx_busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_tx_async", 32'(tx), 32'd1);
        check("midrst_busy_async", 32'(tx_busy), 32'd0);
        read_check("midrst_status_in_rst", STAT, 32'h2);
        tick();
        rst_n = 1'b1;
        lows = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (tx !== 1'b1 || tx_busy !== 1'b0) lows++;
        end
        check("midrst_quiet_cycles", 32'(lows), 32'd0);
        read_check("midrst_status_after", STAT, 32'h2);

        // Address decode
        bus_write(BASE + 32'd8, 32'h55);
        tick();
        check("dec_busy", 32'(tx_busy), 32'd0);
        check("dec_tx", 32'(tx), 32'd1);
        read_check("dec_status", STAT, 32'h2);
        read_check("dec_read_below", BASE - 32'd4, 32'h0);
        read_check("dec_read_data", BASE, 32'h0);
        read_check("dec_read_above", BASE + 32'd8, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/otter_iobus_uart_tx.md
# otter_iobus_uart_tx

Memory-mapped UART transmitter that responds to OTTER CPU IOBUS stores and loads. Writes to its data address are queued in a small FIFO and serialised as 8N1 frames on `TX`. A status register reports FIFO and transmitter state so firmware can poll before writing. It sits beside the other MMIO peripherals on the IOBUS, opposite the CPU's bus-initiator side, as the outbound counterpart of the serial programmer's receive path.

## Interface

Parameters:
- `BASE_ADDR`, default 32'h1100_0100: byte address of the TXDATA register. STATUS is at `BASE_ADDR+4`.
- `CLK_RATE`, default 50: clock frequency in MHz.
- `BAUD`, default 115200: line rate in bit/s.
- `FIFO_DEPTH`, default 8: FIFO depth. Must be a power of two, at least 2.

Ports:
- `CLK` input 1: clock. All logic updates on the rising edge.
- `RESET_N` input 1: asynchronous, active-low reset.
- `IOBUS_ADDR` input 32: byte address from the CPU.
- `IOBUS_OUT` input 32: write data from the CPU.
- `IOBUS_WR` input 1: write strobe, valid for one cycle per store.
- `IOBUS_RD_DATA` output 32: combinational read data. The top level ORs this into `IOBUS_IN`.
- `TX` output 1: serial line, registered, idles high.
- `TX_BUSY` output 1: high while a frame is on the line.

## Operation

Bit period:
- `DIV = (CLK_RATE*1000000 + BAUD/2) / BAUD`, computed at elaboration.
- Default `DIV` = 434.
- The baud counter is `$clog2(DIV)` bits wide and counts 0..DIV-1.

TXDATA write (address `BASE_ADDR`):
- Condition: `IOBUS_WR=1` at `BASE_ADDR`.
- If the FIFO is not full, `IOBUS_OUT[7:0]` is pushed and bits [31:8] are ignored.
- If the FIFO is full, the byte is dropped and sticky `ovf` is set.
- "Full" is sampled before the edge. A write in the same cycle as a pop from a full FIFO is still dropped.

STATUS write (address `BASE_ADDR+4`):
- `IOBUS_OUT[3]=1` clears `ovf`.
- All other bits are ignored.

`IOBUS_RD_DATA`:
- At `BASE_ADDR+4` it returns `{24'b0, count[3:0], ovf, TX_BUSY, empty, full}`. Bit 0 is `full`, bit 1 is `empty`, bit 2 is `TX_BUSY`, bit 3 is `ovf`, bits [7:4] are the FIFO occupancy (saturating at 15).
- At `BASE_ADDR` it returns 0.
- At any other address it returns 0.

Writes to any other address are ignored.

FIFO:
- Circular buffer with `log2(FIFO_DEPTH)`-bit read and write pointers that wrap.
- A separate occupancy count runs 0..FIFO_DEPTH.
- Push and pop in the same cycle leave the count unchanged.

Transmit FSM states are IDLE, START, DATA, STOP:
- **IDLE:** `TX=1`, `TX_BUSY=0`. If the FIFO is non-empty, pop the head into an 8-bit shift register, clear the baud counter and go to START.
- **START:** `TX=0` for DIV cycles, then go to DATA with bit index 0.
- **DATA:** `TX=shift[0]` (LSB first). Each bit is held for DIV cycles, then the register shifts right. After bit index 7 completes, go to STOP.
- **STOP:** `TX=1` for DIV cycles. At the end, if the FIFO is non-empty, pop and go straight to START, with no idle gap between frames. Otherwise go to IDLE.

`TX_BUSY` is 1 in START, DATA and STOP.

Reset (asserting `RESET_N=0`, at any time, including mid-frame):
- `TX` goes to 1 immediately.
- `TX_BUSY=0`, FSM returns to IDLE.
- FIFO is emptied (pointers and count cleared) and `ovf` is cleared.
- The partial frame is abandoned, not completed.
- After reset, a STATUS read returns 32'h0000_0002.

## Timing

- Write at edge N into an empty FIFO while in IDLE:
  - Pop at edge N+1.
  - `TX` falls and `TX_BUSY` rises after edge N+1.
  - STATUS reads `empty=0`, `count=1` during cycle N+1 only.
- Frame length is exactly 10×DIV cycles from the `TX` falling edge to the end of the stop bit.
- Back-to-back frames have no extra idle cycle between them.
- The pop for the next frame happens on the same edge that ends the stop bit.
- `IOBUS_RD_DATA` is combinational from `IOBUS_ADDR` and the current registers, with zero-cycle latency.

## Test plan

Directed tests use `CLK_RATE=1`, `BAUD=250000` (so `DIV=4`) and `FIFO_DEPTH=4`.

- **Reset state:** assert `RESET_N=0`, then release → `TX=1`, `TX_BUSY=0`, STATUS=0x2.
- **Single byte:** write 0xA5 to TXDATA → `TX` falls 1 cycle later; the line carries 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; `TX_BUSY` is high for exactly 40 cycles, then STATUS=0x2.
- **Back-to-back:** write 0x00 then 0xFF on consecutive cycles → two 40-cycle frames with no high gap between the first stop bit and the second start bit.
- **Overflow:** 6 writes in consecutive cycles with the FIFO initially empty → first pops immediately, next 4 fill the FIFO, 6th dropped; STATUS reads 0x4D (count 4, `ovf` set, busy, full). Writing 0x8 to STATUS clears `ovf`. Only 5 frames are sent.
- **Reset mid-frame:** assert `RESET_N=0` during DATA bit 3 with 2 bytes queued → `TX=1` asynchronously, no further frames, STATUS=0x2.
- **Address decode:** write to `BASE_ADDR+8` → no push. A read at `BASE_ADDR-4` → 0.
